// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multi-cycle MIPS controller: opcode values
//   decoded from IR[31:26], the controller state encodings, the datapath
//   select codes (ALUOp, ALUSrcB, PCSource) and a packed bundle that carries
//   every control output.
package mips_pkg;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states. The numeric values are visible on the debug state
    // port, so they are pinned explicitly.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every control output in one bundle so the decode block can clear it
    // with a single default assignment.
    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
//   Connection between the main controller and the datapath it sequences.
//   Datapath -> controller : opcode (IR[31:26]), mem_ready (memory completes
//                            the current access this cycle)
//   Controller -> datapath : PC/IR/memory/register-file enables, mux selects,
//                            illegal_op pulse, debug state and the
//                            retired-instruction count (CNT_W bits)
//   master : the controller side
//   slave  : the datapath side
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, state, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, state, retired
    );

endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle main controller for a shared-ALU / shared-memory MIPS
//   datapath. Steps one instruction at a time through FETCH, DECODE and an
//   opcode-specific tail, stalls the memory states until mem_ready, pulses
//   illegal_op for unsupported opcodes and counts retired instructions.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high; forces every control output low
//     bus    : mc_control_fsm_if.master (opcode/mem_ready in, controls out)
//   Parameters:
//     CNT_W  : width of the retired-instruction counter (wraps)
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             illegal;
    ctrl_t            ctrl;

    // Next-state logic. Also flags the final cycle of every instruction
    // (retire) and unsupported opcodes seen in DECODE (illegal).
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach this state, so anything other than sw is lw.
            S_MEM_ADDR: begin
                state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Encodings 12-15 cannot be reached; fall back to FETCH.
            default:     state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    // State and retired counter. Reset wins over any state, so a stalled or
    // half-finished instruction is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Output decode. Controls follow the state; mem_ready only gates the
    // FETCH-time PC and IR loads. Everything is held low while reset is high.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.MemRead  = 1'b1;
                    ctrl.IorD     = 1'b0;
                    ctrl.ALUSrcA  = 1'b0;
                    ctrl.ALUSrcB  = SRCB_FOUR;
                    ctrl.ALUOp    = ALUOP_ADD;
                    ctrl.PCSource = PCSRC_ALU;
                    ctrl.IRWrite  = bus.mem_ready;
                    ctrl.PCWrite  = bus.mem_ready;
                end
                // Branch target is computed speculatively into ALUOut here.
                S_DECODE: begin
                    ctrl.ALUSrcA    = 1'b0;
                    ctrl.ALUSrcB    = SRCB_IMM_SHL2;
                    ctrl.ALUOp      = ALUOP_ADD;
                    ctrl.illegal_op = illegal;
                end
                S_MEM_ADDR: begin
                    ctrl.ALUSrcA = 1'b1;
                    ctrl.ALUSrcB = SRCB_IMM;
                    ctrl.ALUOp   = ALUOP_ADD;
                end
                S_MEM_READ: begin
                    ctrl.MemRead = 1'b1;
                    ctrl.IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.RegWrite = 1'b1;
                    ctrl.MemtoReg = 1'b1;
                    ctrl.RegDst   = 1'b0;
                end
                S_MEM_WRITE: begin
                    ctrl.MemWrite = 1'b1;
                    ctrl.IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.ALUSrcA = 1'b1;
                    ctrl.ALUSrcB = SRCB_REG;
                    ctrl.ALUOp   = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.RegWrite = 1'b1;
                    ctrl.RegDst   = 1'b1;
                    ctrl.MemtoReg = 1'b0;
                end
                S_BRANCH: begin
                    ctrl.ALUSrcA     = 1'b1;
                    ctrl.ALUSrcB     = SRCB_REG;
                    ctrl.ALUOp       = ALUOP_SUB;
                    ctrl.PCWriteCond = 1'b1;
                    ctrl.PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.PCWrite  = 1'b1;
                    ctrl.PCSource = PCSRC_JUMP;
                end
                S_ADDI_EXEC: begin
                    ctrl.ALUSrcA = 1'b1;
                    ctrl.ALUSrcB = SRCB_IMM;
                    ctrl.ALUOp   = ALUOP_ADD;
                end
                S_ADDI_WB: begin
                    ctrl.RegWrite = 1'b1;
                    ctrl.RegDst   = 1'b0;
                    ctrl.MemtoReg = 1'b0;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.PCWrite     = ctrl.PCWrite;
    assign bus.PCWriteCond = ctrl.PCWriteCond;
    assign bus.IorD        = ctrl.IorD;
    assign bus.MemRead     = ctrl.MemRead;
    assign bus.MemWrite    = ctrl.MemWrite;
    assign bus.IRWrite     = ctrl.IRWrite;
    assign bus.MemtoReg    = ctrl.MemtoReg;
    assign bus.RegDst      = ctrl.RegDst;
    assign bus.RegWrite    = ctrl.RegWrite;
    assign bus.ALUSrcA     = ctrl.ALUSrcA;
    assign bus.ALUSrcB     = ctrl.ALUSrcB;
    assign bus.ALUOp       = ctrl.ALUOp;
    assign bus.PCSource    = ctrl.PCSource;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.state       = state_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Directed plus randomized bench for mc_control_fsm. The expected behaviour
//   is described per instruction as a list of phases (state numbers), with
//   memory phases repeated for each stalled cycle; the expected controls of
//   each phase come from a table of the documented outputs. A small counter
//   width makes the retired-count wrap reachable.
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [CNT_W-1:0] expRetired;
    logic [16:0] obsCtrl;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every control output flattened into one vector for single comparisons
    assign obsCtrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                      bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                      bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                      bus.PCSource, bus.illegal_op};

    function automatic bit isLegal(input logic [5:0] op);
        return (op == RTY) || (op == LW) || (op == SW) ||
               (op == BEQ) || (op == JMP) || (op == ADDI);
    endfunction

    // Documented outputs of each state, same bit order as obsCtrl
    function automatic logic [16:0] specCtrl(input int st, input bit rdy, input bit ill);
        logic       pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic       m2r = 0, rdst = 0, rwr = 0, srcA = 0, illOut = 0;
        logic [1:0] srcB = 2'b00, aluOp = 2'b00, pcSrc = 2'b00;
        case (st)
            0: begin mrd = 1; srcB = 2'b01; irw = rdy; pcw = rdy; end
            1: begin srcB = 2'b11; illOut = ill; end
            2: begin srcA = 1; srcB = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rwr = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin srcA = 1; aluOp = 2'b10; end
            7: begin rwr = 1; rdst = 1; end
            8: begin srcA = 1; aluOp = 2'b01; pcwc = 1; pcSrc = 2'b01; end
            9: begin pcw = 1; pcSrc = 2'b10; end
            10: begin srcA = 1; srcB = 2'b10; end
            11: begin rwr = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srcA,
                srcB, aluOp, pcSrc, illOut};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then let the edge pass
    task automatic applyStimulus(input int expState, input bit rdy,
                                 input logic [5:0] op, input bit ill);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        @(negedge clk);
        checkOutput($sformatf("state(exp %0d)", expState), 32'(bus.state), 32'(expState));
        checkOutput($sformatf("ctrl(st %0d rdy %0d)", expState, rdy), 32'(obsCtrl),
                    32'(specCtrl(expState, rdy, ill)));
        checkOutput($sformatf("retired(st %0d)", expState), 32'(bus.retired), 32'(expRetired));
        @(posedge clk);
        #1;
    endtask

    // Run one whole instruction from FETCH, stalling the fetch and the data
    // access phases the requested number of cycles.
    task automatic runInstr(input logic [5:0] op, input int fetchStall, input int memStall);
        int  phases[$];
        bit  legal;
        legal  = isLegal(op);
        phases = {0, 1};
        if (op == LW)   phases = {0, 1, 2, 3, 4};
        if (op == SW)   phases = {0, 1, 2, 5};
        if (op == RTY)  phases = {0, 1, 6, 7};
        if (op == BEQ)  phases = {0, 1, 8};
        if (op == JMP)  phases = {0, 1, 9};
        if (op == ADDI) phases = {0, 1, 10, 11};
        foreach (phases[i]) begin
            int  p;
            bit  isMem;
            int  stalls;
            p      = phases[i];
            isMem  = (p == 0) || (p == 3) || (p == 5);
            stalls = !isMem ? 0 : ((p == 0) ? fetchStall : memStall);
            for (int k = 0; k <= stalls; k++) begin
                bit rdy;
                logic [5:0] drv;
                rdy = isMem ? (k == stalls) : bit'($urandom_range(0, 1));
                // IR is not yet meaningful during FETCH, so drive junk there
                drv = (p == 0) ? 6'($urandom) : op;
                applyStimulus(p, rdy, drv, (p == 1) && !legal);
            end
        end
        if (legal) expRetired = expRetired + 1'b1;
    endtask

    function automatic logic [5:0] randomIllegal();
        logic [5:0] op;
        op = 6'($urandom);
        for (int t = 0; t < 64 && isLegal(op); t++) op = 6'($urandom);
        if (isLegal(op)) op = 6'b111111;
        return op;
    endfunction

    initial begin
        logic [5:0] legalOps[6];
        legalOps   = '{RTY, LW, SW, BEQ, JMP, ADDI};
        checks     = 0;
        failures   = 0;
        expRetired = '0;
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;

        $display("[TB] reset sequence");
        @(negedge clk);
        checkOutput("reset_ctrl_cycle0", 32'(obsCtrl), 32'd0);
        @(negedge clk);
        checkOutput("reset_ctrl_cycle1", 32'(obsCtrl), 32'd0);
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] lw with memory always ready");
        runInstr(LW, 0, 0);
        checkOutput("lw_retired", 32'(bus.retired), 32'd1);

        $display("[TB] sw stalled three cycles in MEM_WRITE");
        runInstr(SW, 0, 3);
        checkOutput("sw_retired", 32'(bus.retired), 32'd2);

        $display("[TB] R-type, beq, j, addi");
        runInstr(RTY, 0, 0);
        runInstr(BEQ, 0, 0);
        runInstr(JMP, 0, 0);
        runInstr(ADDI, 0, 0);
        checkOutput("seq_retired", 32'(bus.retired), 32'd6);

        $display("[TB] illegal opcode");
        runInstr(6'b111111, 0, 0);
        checkOutput("illegal_retired", 32'(bus.retired), 32'd6);

        $display("[TB] randomized instruction mix");
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = randomIllegal();
            else op = legalOps[$urandom_range(0, 5)];
            runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("[TB] reset while stalled in MEM_READ");
        runInstr(JMP, 0, 0);
        applyStimulus(0, 1'b1, 6'($urandom), 1'b0);
        applyStimulus(1, 1'b0, LW, 1'b0);
        applyStimulus(2, 1'b1, LW, 1'b0);
        applyStimulus(3, 1'b0, LW, 1'b0);
        applyStimulus(3, 1'b0, LW, 1'b0);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("midreset_ctrl", 32'(obsCtrl), 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        expRetired = '0;
        checkOutput("midreset_state", 32'(bus.state), 32'd0);
        checkOutput("midreset_retired", 32'(bus.retired), 32'd0);

        $display("[TB] retired counter wrap");
        for (int n = 0; n < 15; n++) runInstr(legalOps[$urandom_range(0, 5)], 0, 0);
        checkOutput("wrap_full", 32'(bus.retired), 32'd15);
        runInstr(BEQ, 0, 0);
        checkOutput("wrap_zero", 32'(bus.retired), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
